// File: rtl/bus_wr_pkg.sv
// Shared types and defaults for the decoder write path (st2bus -> bus_wr_ctrl).
// Combinational definitions only; no latency and no backpressure.
package bus_wr_pkg;

    localparam int BUS_W_DEF                 = 512;
    localparam int NUM_BUS_PER_TURBO_PKT_DEF = 2;
    // Covers the registered bus_ready -> bus_en round trip through st2bus.
    localparam int READY_HEADROOM            = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/bus_wr_ctrl_if.sv
// Bus-line input and memory-write output bundle of bus_wr_ctrl.
// master = the controller, slave = st2bus plus the memory write port.
interface bus_wr_ctrl_if
    import bus_wr_pkg::*;
#(
    parameter int BUS_W  = BUS_W_DEF,
    parameter int ADDR_W = 32
) ();

    logic [BUS_W-1:0]  bus_data;
    logic              bus_en;
    logic              bus_ready;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [BUS_W-1:0]  wr_data;
    logic              wr_almost_full;

    modport master (
        input  bus_data, bus_en, wr_almost_full,
        output bus_ready, wr_req, wr_addr, wr_data
    );

    modport slave (
        output bus_data, bus_en, wr_almost_full,
        input  bus_ready, wr_req, wr_addr, wr_data
    );

endinterface

// File: rtl/bus_wr_fifo.sv
// Synchronous show-ahead FIFO; pop data valid combinationally while not empty.
// Push when full and pop when empty are ignored; a pop never frees a slot for a same-cycle push.
module bus_wr_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic                     clk_bus,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_bus) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/bus_wr_ctrl.sv
// Buffers st2bus lines and issues line-addressed memory writes, 1 cycle after the pop decision;
// stalls on wr_almost_full, throttles st2bus via bus_ready. WR_CTRL_PERF_EN adds perf counters.
module bus_wr_ctrl
    import bus_wr_pkg::*;
#(
    parameter int BUS_W                 = BUS_W_DEF,
    parameter int NUM_BUS_PER_TURBO_PKT = NUM_BUS_PER_TURBO_PKT_DEF,
    parameter int FIFO_DEPTH            = 8,
    parameter int ADDR_W                = 32,
    parameter int PKT_CNT_W             = 16
) (
    input  logic                        clk_bus,
    input  logic                        rst_n,
    input  logic                        cfg_start,
    input  logic [ADDR_W-1:0]           cfg_base_addr,
    input  logic [PKT_CNT_W-1:0]        cfg_num_pkt,
    bus_wr_ctrl_if.master               bus,
    output logic                        pkt_done,
    output logic                        all_done,
    output logic                        err_ovf
`ifdef WR_CTRL_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cnt,
    output logic [$clog2(FIFO_DEPTH):0] perf_fifo_max
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] READY_MIN = CW'(NUM_BUS_PER_TURBO_PKT + READY_HEADROOM);

    wr_state_t            state;
    logic [ADDR_W-1:0]    addr_cnt;
    logic [PKT_CNT_W-1:0] num_pkt_l;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic [LW-1:0]        line_idx;

    logic [BUS_W-1:0]     fifo_dat;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_n;
    logic                 full;
    logic                 empty;
    logic                 start;
    logic                 push_ok;
    logic                 drop;
    logic                 pop;
    logic                 line_last;
    logic                 pkt_last;
    logic                 job_end;
    logic                 room_ok;

    assign start     = cfg_start && (state != RUN);
    assign push_ok   = bus.bus_en && (state == RUN) && !full;
    assign drop      = bus.bus_en && !push_ok;
    assign pop       = !empty && !bus.wr_almost_full && (state == RUN);
    assign line_last = (line_idx == LW'(NUM_BUS_PER_TURBO_PKT - 1));
    assign pkt_last  = ((pkt_cnt + PKT_CNT_W'(1)) == num_pkt_l);
    assign job_end   = pop && line_last && pkt_last;
    assign count_n   = count + CW'(push_ok) - CW'(pop);
    assign room_ok   = ((DEPTH_C - count_n) >= READY_MIN);

    // A new job flushes anything left over from the previous one.
    bus_wr_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_bus  (clk_bus),
        .rst_n    (rst_n),
        .clr      (start),
        .push     (push_ok),
        .push_dat (bus.bus_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.bus_ready <= 1'b0;
            bus.wr_req    <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            pkt_done      <= 1'b0;
            all_done      <= 1'b0;
            err_ovf       <= 1'b0;
            addr_cnt      <= '0;
            num_pkt_l     <= '0;
            line_idx      <= '0;
            pkt_cnt       <= '0;
        end else begin
            bus.wr_req <= pop;
            pkt_done   <= pop && line_last;
            err_ovf    <= start ? 1'b0 : (err_ovf | drop);

            if (pop) begin
                bus.wr_data <= fifo_dat;
                bus.wr_addr <= addr_cnt;
                addr_cnt    <= addr_cnt + ADDR_W'(1);
                line_idx    <= line_last ? '0 : line_idx + LW'(1);
                if (line_last) begin
                    pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
                end
            end

            case (state)
                RUN: begin
                    all_done <= 1'b0;
                    if (job_end) begin
                        state         <= DONE;
                        bus.bus_ready <= 1'b0;
                    end else begin
                        bus.bus_ready <= room_ok;
                    end
                end
                IDLE, DONE: begin
                    all_done      <= (state == DONE) && !cfg_start;
                    bus.bus_ready <= 1'b0;
                    if (cfg_start) begin
                        addr_cnt  <= cfg_base_addr;
                        num_pkt_l <= cfg_num_pkt;
                        line_idx  <= '0;
                        pkt_cnt   <= '0;
                        if (cfg_num_pkt == '0) begin
                            state <= DONE;
                        end else begin
                            // FIFO is flushed on this edge, so full headroom is available.
                            state         <= RUN;
                            bus.bus_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    all_done      <= 1'b0;
                    bus.bus_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef WR_CTRL_PERF_EN
    always_ff @(posedge clk_bus) begin
        if (!rst_n || start) begin
            perf_stall_cnt <= '0;
            perf_fifo_max  <= '0;
        end else begin
            if ((state == RUN) && !empty && bus.wr_almost_full && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (count > perf_fifo_max) begin
                perf_fifo_max <= count;
            end
        end
    end
`endif

endmodule
